// File: rtl/alu_check_pkg.sv
// Shared opcodes, FSM encoding and flag helpers for the ALU vector checker.
package alu_check_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  localparam int ZCV_Z = 2;
  localparam int ZCV_C = 1;
  localparam int ZCV_V = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Carry and overflow are meaningless for logic ops, so they can be masked out.
  function automatic logic [2:0] zcv_mask(input logic [3:0] op, input logic flag_mode);
    logic [2:0] m;
    m = 3'b111;
    if (flag_mode && (op != OP_ADD) && (op != OP_SUB)) begin
      m[ZCV_C] = 1'b0;
      m[ZCV_V] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_check_delay.sv
// Shift register with per-stage valid and synchronous clear; carries expected
// values alongside the ALU pipeline.
module alu_check_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q  <= '0;
      data_q <= '{default: '0};
    end else begin
      vld_q[0]  <= in_vld;
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/alu_vector_checker.sv
// Streams stored vectors from a ROM into an ALU and scores its responses.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   ISSUE | addressing vectors 0..N_VEC-1, one per cycle
//   DRAIN | waiting for the last compare to retire
//   DONE  | results held until start or rst
module alu_vector_checker
  import alu_check_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int N_VEC     = 6,
  parameter int AW        = 6,
  parameter int DUT_LAT   = 1,
  parameter int FLAG_MODE = 1,
  parameter int ERR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     vec_addr,
  input  logic [DATA_W-1:0] vec_src1,
  input  logic [DATA_W-1:0] vec_src2,
  input  logic [3:0]        vec_op,
  input  logic [DATA_W-1:0] vec_exp_result,
  input  logic [2:0]        vec_exp_zcv,
  output logic [DATA_W-1:0] dut_src1,
  output logic [DATA_W-1:0] dut_src2,
  output logic [3:0]        dut_op,
  input  logic [DATA_W-1:0] dut_result,
  input  logic [2:0]        dut_zcv,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_vld,
  output logic [AW-1:0]     first_err_idx,
  output logic              mismatch
);

  localparam int               PW       = AW + 4 + DATA_W + 3;
  localparam logic [AW-1:0]    LAST_IDX = AW'(N_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t            state;
  logic              rom_vld;
  logic [AW-1:0]     rom_idx;
  logic              cmp_vld;
  logic [AW-1:0]     cmp_idx;
  logic [3:0]        cmp_op;
  logic [DATA_W-1:0] cmp_res;
  logic [2:0]        cmp_zcv;
  logic [2:0]        cmp_mask;

  // ROM data for the vector addressed last cycle enters the delay line here,
  // so the line only has to cover the ALU-input register plus DUT_LAT.
  alu_check_delay #(
    .WIDTH (PW),
    .DEPTH (DUT_LAT + 1)
  ) u_delay (
    .clk      (clk),
    .clr      (rst),
    .in_vld   (rom_vld),
    .in_data  ({rom_idx, vec_op, vec_exp_result, vec_exp_zcv}),
    .out_vld  (cmp_vld),
    .out_data ({cmp_idx, cmp_op, cmp_res, cmp_zcv})
  );

  assign cmp_mask = zcv_mask(cmp_op, FLAG_MODE != 0);
  assign mismatch = cmp_vld &&
                    ((dut_result != cmp_res) || (((dut_zcv ^ cmp_zcv) & cmp_mask) != 3'b000));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vec_addr      <= '0;
      rom_vld       <= 1'b0;
      rom_idx       <= '0;
      dut_src1      <= '0;
      dut_src2      <= '0;
      dut_op        <= '0;
      err_count     <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      rom_vld <= (state == ISSUE);
      rom_idx <= vec_addr;
      if (rom_vld) begin
        dut_src1 <= vec_src1;
        dut_src2 <= vec_src2;
        dut_op   <= vec_op;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= ISSUE;
            vec_addr      <= '0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
          end
        end
        ISSUE: begin
          if (vec_addr == LAST_IDX) state <= DRAIN;
          else                      vec_addr <= vec_addr + 1'b1;
        end
        DRAIN: begin
          if (cmp_vld && (cmp_idx == LAST_IDX)) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      // Compares only retire in ISSUE/DRAIN, so this never races the clear on start.
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= cmp_idx;
        end
      end
    end
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_alu_vector_checker.sv
// Scoreboard bench: three checker configurations, each driving a behavioural ALU.
module tb_alu_vector_checker;
  import alu_check_pkg::*;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  op;
    logic [31:0] res;
    logic [2:0]  zcv;
  } vec_t;

  typedef struct {
    bit is_done;
    int cyc;
    int err;
    bit fev;
    int fidx;
    bit pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   act = 0;

  logic start_v [3];
  vec_t rom [3][6];
  vec_t gold [6];

  logic        mism_a [3];
  logic        done_a [3];
  logic        busy_a [3];
  logic        pass_a [3];
  logic        fev_a [3];
  logic [5:0]  err_a [3];
  logic [5:0]  addr_a [3];
  logic [5:0]  fidx_a [3];
  logic [31:0] dsrc1_a [3];
  logic [3:0]  dop_a [3];

  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic c, v;
    sum = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[31:0]; c = sum[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = sum[31:0]; c = sum[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return {r, (r == 32'd0), c, v};
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int NV  = (g == 2) ? 1 : 6;
      localparam int LAT = (g == 2) ? 0 : 1;
      localparam int FM  = (g == 1) ? 0 : 1;
      localparam int EW  = (g == 1) ? 2 : 6;

      logic [5:0]    vec_addr, first_err_idx;
      logic [31:0]   vec_src1, vec_src2, vec_exp_result;
      logic [31:0]   dut_src1, dut_src2, dut_result;
      logic [3:0]    vec_op, dut_op;
      logic [2:0]    vec_exp_zcv, dut_zcv;
      logic          busy, done, pass, first_err_vld, mismatch;
      logic [EW-1:0] err_count;
      logic [34:0]   alu_now;

      alu_vector_checker #(
        .DATA_W(32), .N_VEC(NV), .AW(6), .DUT_LAT(LAT), .FLAG_MODE(FM), .ERR_W(EW)
      ) dut (
        .clk(clk), .rst(rst), .start(start_v[g]), .vec_addr(vec_addr),
        .vec_src1(vec_src1), .vec_src2(vec_src2), .vec_op(vec_op),
        .vec_exp_result(vec_exp_result), .vec_exp_zcv(vec_exp_zcv),
        .dut_src1(dut_src1), .dut_src2(dut_src2), .dut_op(dut_op),
        .dut_result(dut_result), .dut_zcv(dut_zcv),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vld(first_err_vld), .first_err_idx(first_err_idx), .mismatch(mismatch)
      );

      always @(posedge clk)
        {vec_src1, vec_src2, vec_op, vec_exp_result, vec_exp_zcv} <= rom[g][vec_addr[2:0]];

      assign alu_now = alu_ref(dut_op, dut_src1, dut_src2);
      if (LAT == 0) begin : g_comb
        assign {dut_result, dut_zcv} = alu_now;
      end else begin : g_reg
        always @(posedge clk) {dut_result, dut_zcv} <= alu_now;
      end

      assign mism_a[g]  = mismatch;
      assign done_a[g]  = done;
      assign busy_a[g]  = busy;
      assign pass_a[g]  = pass;
      assign fev_a[g]   = first_err_vld;
      assign err_a[g]   = 6'(err_count);
      assign addr_a[g]  = vec_addr;
      assign fidx_a[g]  = first_err_idx;
      assign dsrc1_a[g] = dut_src1;
      assign dop_a[g]   = dut_op;
    end
  endgenerate

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, cfg %0d)", name, got, want, cyc, act);
    end
  endtask

  // Monitor: pops the next expected event whenever the active instance reports one.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (mism_a[act]) begin
      if (exp_q.size() == 0) chk("mismatch_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("mismatch_kind", e.is_done, 0);
        chk("mismatch_cycle", cyc, e.cyc);
        chk("busy_at_mismatch", busy_a[act], 1);
      end
    end
    if (done_a[act] && !done_prev) begin
      if (exp_q.size() == 0) chk("done_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("done_kind", e.is_done, 1);
        chk("done_cycle", cyc, e.cyc);
        chk("err_count", err_a[act], e.err);
        chk("first_err_vld", fev_a[act], e.fev);
        chk("first_err_idx", fidx_a[act], e.fidx);
        chk("pass", pass_a[act], e.pass);
        chk("busy_at_done", busy_a[act], 0);
      end
    end
    done_prev = done_a[act];
  end

  task automatic push_mis(input int c);
    exp_t e;
    e = '{is_done: 1'b0, cyc: c, err: 0, fev: 1'b0, fidx: 0, pass: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c, input int err, input bit fev, input int fidx, input bit p);
    exp_t e;
    e = '{is_done: 1'b1, cyc: c, err: err, fev: fev, fidx: fidx, pass: p};
    exp_q.push_back(e);
  endtask

  // Returns s, the first issue cycle; with hold, start stays high through s.
  task automatic start_run(input int g, input bit hold, output int s);
    @(posedge clk); #1 start_v[g] = 1'b1;
    @(posedge clk); #1 s = cyc;
    if (hold) begin
      @(posedge clk); #1;
    end
    start_v[g] = 1'b0;
  endtask

  task automatic wait_retired();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
    #1 chk("events_retired", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
    gold[0] = '{s1: 32'd5,          s2: 32'd7,          op: OP_ADD, res: 32'd12,         zcv: 3'b000};
    gold[1] = '{s1: 32'd3,          s2: 32'd3,          op: OP_SUB, res: 32'd0,          zcv: 3'b110};
    gold[2] = '{s1: 32'hF0F0F0F0,   s2: 32'h0F0F0F0F,   op: OP_AND, res: 32'd0,          zcv: 3'b100};
    gold[3] = '{s1: 32'd5,          s2: 32'd3,          op: OP_SLT, res: 32'd0,          zcv: 3'b100};
    gold[4] = '{s1: 32'd0,          s2: 32'd0,          op: OP_NOR, res: 32'hFFFFFFFF,   zcv: 3'b000};
    gold[5] = '{s1: 32'h7FFFFFFF,   s2: 32'd1,          op: OP_ADD, res: 32'h80000000,   zcv: 3'b001};
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 6; i++) rom[g][i] = gold[i];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    act = 0;
    chk("reset_vec_addr", addr_a[0], 0);
    chk("reset_busy", busy_a[0], 0);
    chk("reset_done", done_a[0], 0);
    chk("reset_pass", pass_a[0], 0);
    chk("reset_err_count", err_a[0], 0);
    chk("reset_first_err_vld", fev_a[0], 0);
    chk("reset_dut_src1", dsrc1_a[0], 0);
    chk("reset_mismatch", mism_a[0], 0);

    // golden run
    start_run(0, 1'b0, s);
    push_done(s + 9, 0, 1'b0, 0, 1'b1);
    wait_retired();
    chk("done_vec_addr_hold", addr_a[0], 5);
    chk("dut_src1_hold", dsrc1_a[0], 32'h7FFFFFFF);
    chk("dut_op_hold", dop_a[0], OP_ADD);

    // vector 3 expects 1, ALU returns 0; restart from DONE
    rom[0][3].res = 32'd1;
    start_run(0, 1'b0, s);
    push_mis(s + 6);
    push_done(s + 9, 1, 1'b1, 3, 1'b0);
    wait_retired();

    // FLAG_MODE=1: cout error on AND ignored, on SUB counted
    rom[0][3] = gold[3];
    rom[0][2].zcv = 3'b110;
    rom[0][1].zcv = 3'b100;
    start_run(0, 1'b0, s);
    push_mis(s + 4);
    push_done(s + 9, 1, 1'b1, 1, 1'b0);
    wait_retired();

    // mid-run reset while a mismatch is being scored
    for (int i = 0; i < 6; i++) rom[0][i] = gold[i];
    rom[0][0].res = 32'd13;
    start_run(0, 1'b0, s);
    push_mis(s + 3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_events_retired", exp_q.size(), 0);
    chk("abort_vec_addr", addr_a[0], 0);
    chk("abort_err_count", err_a[0], 0);
    chk("abort_first_err_vld", fev_a[0], 0);
    chk("abort_busy", busy_a[0], 0);
    chk("abort_done", done_a[0], 0);
    chk("abort_dut_src1", dsrc1_a[0], 0);
    rom[0][0] = gold[0];
    start_run(0, 1'b0, s);
    push_done(s + 9, 0, 1'b0, 0, 1'b1);
    wait_retired();

    // FLAG_MODE=0, ERR_W=2: both flag errors count, then saturation
    act = 1;
    rom[1][2].zcv = 3'b110;
    rom[1][1].zcv = 3'b100;
    start_run(1, 1'b0, s);
    push_mis(s + 4);
    push_mis(s + 5);
    push_done(s + 9, 2, 1'b1, 1, 1'b0);
    wait_retired();

    for (int i = 0; i < 6; i++) begin
      rom[1][i] = gold[i];
      rom[1][i].res = gold[i].res ^ 32'd1;
    end
    start_run(1, 1'b0, s);
    for (int i = 0; i < 6; i++) push_mis(s + 3 + i);
    push_done(s + 9, 3, 1'b1, 0, 1'b0);
    wait_retired();

    // N_VEC=1, DUT_LAT=0: start held into ISSUE is ignored
    act = 2;
    rom[2][0].res = 32'd13;
    start_run(2, 1'b1, s);
    push_mis(s + 2);
    push_done(s + 3, 1, 1'b1, 0, 1'b0);
    wait_retired();
    chk("n1_vec_addr", addr_a[2], 0);

    rom[2][0] = gold[0];
    start_run(2, 1'b0, s);
    push_done(s + 3, 0, 1'b0, 0, 1'b1);
    wait_retired();
    chk("n1_dut_op", dop_a[2], OP_ADD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
